// File: rtl/fifo_stream_drain.sv
// Read-side drain for a synchronous FIFO: pops words into a 2-entry skid buffer and streams them
// out on valid/ready, marking every BURST_LEN-th word with m_last and counting finished bursts.
module fifo_stream_drain #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned BCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [BCNT_WIDTH-1:0] burst_count
);

    localparam logic [7:0] LastIdx = 8'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic [1:0]            count_q, count_d;
    logic                  rd_idx_q, rd_idx_d;
    logic                  wr_idx_q, wr_idx_d;
    logic                  pending_q, pending_d;
    logic [7:0]            widx_q, widx_d;
    logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d;

    logic       pop;
    logic       push;
    logic [1:0] occupancy;

    always_comb begin
        m_valid     = (count_q != 2'd0);
        m_data      = buf_q[rd_idx_q];
        m_last      = m_valid && (widx_q == LastIdx);
        burst_count = bcnt_q;

        pop  = m_valid && m_ready;
        push = pending_q;

        // Slots committed after this edge; count + pending never exceeds 2, so 2 bits suffice.
        occupancy  = count_q + {1'b0, pending_q} - {1'b0, pop};
        fifo_rd_en = !fifo_empty && (occupancy < 2'd2);
    end

    always_comb begin
        buf_d     = buf_q;
        count_d   = count_q;
        rd_idx_d  = rd_idx_q;
        wr_idx_d  = wr_idx_q;
        pending_d = fifo_rd_en;
        widx_d    = widx_q;
        bcnt_d    = bcnt_q;

        if (push) begin
            buf_d[wr_idx_q] = fifo_data;
            wr_idx_d        = ~wr_idx_q;
        end
        if (pop) begin
            rd_idx_d = ~rd_idx_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        if (pop) begin
            if (m_last) begin
                widx_d = 8'd0;
                bcnt_d = bcnt_q + 1'b1;
            end else begin
                widx_d = widx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q     <= '{default: '0};
            count_q   <= 2'd0;
            rd_idx_q  <= 1'b0;
            wr_idx_q  <= 1'b0;
            pending_q <= 1'b0;
            widx_q    <= 8'd0;
            bcnt_q    <= '0;
        end else begin
            buf_q     <= buf_d;
            count_q   <= count_d;
            rd_idx_q  <= rd_idx_d;
            wr_idx_q  <= wr_idx_d;
            pending_q <= pending_d;
            widx_q    <= widx_d;
            bcnt_q    <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Self-checking bench for fifo_stream_drain: behavioural FIFO source, scoreboard of words read,
// and a stream monitor checking order, burst framing, counters and hold-while-stalled.
module tb_fifo_stream_drain;

    localparam int unsigned DW = 32;
    localparam int unsigned BL = 8;
    localparam int unsigned BW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [BW-1:0] burst_count;

    // Wrap instance: BURST_LEN=1, 4-bit burst counter
    logic       b_empty;
    logic [7:0] b_fdata;
    logic       b_rd_en;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] b_data;
    logic       b_last;
    logic [3:0] b_bcnt;

    fifo_stream_drain #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .BCNT_WIDTH(BW)
    ) u_dut (
        .clk        (clk),
        .reset      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .burst_count(burst_count)
    );

    fifo_stream_drain #(
        .DATA_WIDTH(8),
        .BURST_LEN (1),
        .BCNT_WIDTH(4)
    ) u_dut_wrap (
        .clk        (clk),
        .reset      (rst_n),
        .fifo_empty (b_empty),
        .fifo_data  (b_fdata),
        .fifo_rd_en (b_rd_en),
        .m_valid    (b_valid),
        .m_ready    (b_ready),
        .m_data     (b_data),
        .m_last     (b_last),
        .burst_count(b_bcnt)
    );

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [7:0]    src_b[$];
    logic [7:0]    exp_b[$];

    int n_checks    = 0;
    int n_errors    = 0;
    int reads       = 0;
    int pops_seen   = 0;
    int pop_idx     = 0;
    int exp_bursts  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // FIFO source models: read data returns the cycle after the strobe.
    initial begin : model_a
        logic [DW-1:0] w;
        forever begin
            @(posedge clk);
            if (fifo_rd_en && src_q.size() != 0) begin
                w = src_q.pop_front();
                fifo_data <= w;
                if (rst_n) begin
                    exp_q.push_back(w);
                    reads++;
                end
            end
            fifo_empty <= (src_q.size() == 0);
        end
    end

    initial begin : model_b
        logic [7:0] w;
        forever begin
            @(posedge clk);
            if (b_rd_en && src_b.size() != 0) begin
                w = src_b.pop_front();
                b_fdata <= w;
                if (rst_n) exp_b.push_back(w);
            end
            b_empty <= (src_b.size() == 0);
        end
    end

    // Reset discards the buffer and any in-flight read.
    initial begin : flush_on_reset
        forever begin
            @(negedge rst_n);
            exp_q.delete();
            exp_b.delete();
        end
    end

    initial begin : monitor_a
        logic          hold_q;
        logic [DW-1:0] hold_data;
        logic          hold_last;
        hold_q = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pop_idx    = 0;
                exp_bursts = 0;
                hold_q     = 1'b0;
            end else begin
                if (hold_q) begin
                    check_eq("hold_valid", m_valid, 1);
                    check_eq("hold_data", m_data, hold_data);
                    check_eq("hold_last", m_last, hold_last);
                end
                if (m_valid && m_ready) begin
                    check_eq("pop_bcnt", burst_count, exp_bursts);
                    check_eq("pop_last", m_last, (pop_idx == BL - 1));
                    if (exp_q.size() == 0) check_eq("spurious_word", exp_q.size(), 1);
                    else check_eq("pop_data", m_data, exp_q.pop_front());
                    pops_seen++;
                    if (pop_idx == BL - 1) begin
                        pop_idx = 0;
                        exp_bursts++;
                    end else begin
                        pop_idx++;
                    end
                    hold_q = 1'b0;
                end else if (m_valid) begin
                    hold_q    = 1'b1;
                    hold_data = m_data;
                    hold_last = m_last;
                end else begin
                    hold_q = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        m_ready = 1'b0;
        b_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_a(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) src_q.push_back(base + DW'(i));
        fifo_empty = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input bit rand_ready,
                             output int cycles);
        int target;
        target = pops_seen + n;
        cycles = 0;
        while (pops_seen < target && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        end
        if (pops_seen < target) check_eq("pop_timeout", pops_seen, target);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin : stimulus
        int cyc;
        int k;
        fifo_empty = 1'b1;
        b_empty    = 1'b1;
        fifo_data  = '0;
        b_fdata    = '0;

        // Reset state and idle
        do_reset();
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_last", m_last, 0);
        check_eq("rst_data", m_data, 0);
        check_eq("rst_bcnt", burst_count, 0);
        repeat (10) begin
            @(negedge clk);
            check_eq("idle_rd_en", fifo_rd_en, 0);
            check_eq("idle_valid", m_valid, 0);
            check_eq("idle_bcnt", burst_count, 0);
        end
        @(posedge clk);
        #1;

        // Streaming: 2 cycles from first read to first pop, then one word per cycle
        m_ready = 1'b1;
        load_a(16, 32'h1);
        wait_pops(16, 40, 1'b0, cyc);
        check_eq("stream_cycles", cyc, 18);
        check_eq("stream_bcnt", burst_count, 2);
        check_eq("stream_left", exp_q.size(), 0);

        // Backpressure: only two reads while stalled, then no gaps
        do_reset();
        reads = 0;
        load_a(4, 32'h100);
        repeat (5) @(posedge clk);
        #1;
        check_eq("bp_reads", reads, 2);
        check_eq("bp_rd_en", fifo_rd_en, 0);
        check_eq("bp_valid", m_valid, 1);
        check_eq("bp_data", m_data, 32'h100);
        m_ready = 1'b1;
        wait_pops(4, 20, 1'b0, cyc);
        check_eq("bp_drain_cycles", cyc, 4);
        check_eq("bp_left", exp_q.size(), 0);

        // Random ready over 1000 words
        do_reset();
        load_a(1000, 32'h1000);
        m_ready = 1'($urandom_range(0, 1));
        wait_pops(1000, 8000, 1'b1, cyc);
        check_eq("rand_bcnt", burst_count, 125);
        check_eq("rand_left", exp_q.size(), 0);
        check_eq("rand_src_left", src_q.size(), 0);

        // Reset in the middle of a burst with a read pending
        do_reset();
        m_ready = 1'b1;
        load_a(20, 32'h2000);
        wait_pops(3, 20, 1'b0, cyc);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", m_valid, 0);
        check_eq("midrst_last", m_last, 0);
        check_eq("midrst_data", m_data, 0);
        check_eq("midrst_bcnt", burst_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_pops(8, 30, 1'b0, cyc);
        check_eq("midrst_burst_done", burst_count, 1);
        m_ready = 1'b0;
        src_q.delete();
        fifo_empty = 1'b1;

        // Counter wrap on the BURST_LEN=1 instance
        do_reset();
        for (int i = 1; i <= 17; i++) src_b.push_back(8'(i));
        b_empty = 1'b0;
        b_ready = 1'b1;
        k   = 0;
        cyc = 0;
        while (k < 17 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (b_valid) begin
                check_eq("wrap_last", b_last, 1);
                check_eq("wrap_bcnt", b_bcnt, k % 16);
                if (exp_b.size() == 0) check_eq("wrap_spurious", exp_b.size(), 1);
                else check_eq("wrap_data", b_data, exp_b.pop_front());
                k++;
            end
        end
        if (k < 17) check_eq("wrap_timeout", k, 17);
        @(posedge clk);
        #1;
        check_eq("wrap_final_bcnt", b_bcnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
